// File: rtl/capture_frame_scheduler_pkg.sv
// Shared widths, frame layout and FSM states for the capture frame scheduler.
// OVERFLOW_COUNT_EN appends a drop-count byte to every frame.
package capture_frame_scheduler_pkg;

    localparam int unsigned PIN_WIDTH        = 8;
    localparam int unsigned TS_WIDTH         = 32;
    localparam int unsigned FRAME_BYTES_BASE = 5;
`ifdef OVERFLOW_COUNT_EN
    localparam int unsigned FRAME_BYTES      = FRAME_BYTES_BASE + 1;
`else
    localparam int unsigned FRAME_BYTES      = FRAME_BYTES_BASE;
`endif
    localparam int unsigned ENTRY_WIDTH      = PIN_WIDTH + TS_WIDTH;
    localparam int unsigned SHADOW_WIDTH     = FRAME_BYTES * 8;
    localparam int unsigned IDX_WIDTH        = 3;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RELOAD
    } state_t;

    // Byte 0 sits in the top of the shadow so the frame reads MSB-first.
    function automatic logic [7:0] frame_byte(input logic [SHADOW_WIDTH-1:0] frame,
                                              input logic [IDX_WIDTH-1:0]    idx);
        logic [7:0] b;
        b = '0;
        for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
            if (idx == i[IDX_WIDTH-1:0]) b = frame[SHADOW_WIDTH-1-8*i -: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/capture_frame_scheduler_event_fifo.sv
// Show-ahead synchronous FIFO holding {pins, timestamp} capture events.
module event_fifo
    import capture_frame_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = ENTRY_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_pop  = pop && !empty;
    // A pop frees the slot this same edge, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/capture_frame_scheduler.sv
// Logic-analyser capture: pin sync, change stamping, event FIFO and SPI frame sequencing.
// Optional macro OVERFLOW_COUNT_EN adds a saturating drop counter reported as frame byte 5.
module capture_frame_scheduler
    import capture_frame_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIN_WIDTH-1:0]   pin_values,
    input  logic                   spi_active,
    input  logic                   byte_done,
    output logic [7:0]             tx_byte,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
);

    logic [SYNC_STAGES-1:0][PIN_WIDTH-1:0] sync_q;
    logic [PIN_WIDTH-1:0]    sync_pins;
    logic [PIN_WIDTH-1:0]    last_pins;
    logic [TS_WIDTH-1:0]     ts;
    logic                    pin_event;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic                    drop;
    logic [ENTRY_WIDTH-1:0]  fifo_head;
    logic [ENTRY_WIDTH-1:0]  entry_src;
    logic [SHADOW_WIDTH-1:0] shadow;
    logic [SHADOW_WIDTH-1:0] shadow_src;
    logic                    src_fifo;
    logic [IDX_WIDTH-1:0]    idx;
    state_t                  state;
    state_t                  state_next;
    logic                    load_shadow;
    logic                    idx_inc;
    logic                    frame_done;

    assign sync_pins = sync_q[SYNC_STAGES-1];
    assign pin_event = sync_pins != last_pins;
    assign drop      = pin_event && fifo_full && !fifo_pop;
    assign fifo_pop  = frame_done && src_fifo;
    assign entry_src = fifo_empty ? {sync_pins, ts} : fifo_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            last_pins <= '0;
            ts        <= '0;
            overflow  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_values};
            ts     <= ts + 1'b1;
            if (pin_event) last_pins <= sync_pins;
            if (drop)      overflow  <= 1'b1;
        end
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_event_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pin_event),
        .pop   (fifo_pop),
        .din   ({sync_pins, ts}),
        .dout  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef OVERFLOW_COUNT_EN
    logic [7:0] drop_cnt;
    logic [7:0] drop_cnt_dec;

    // Only the amount latched into the completed frame is retired; later drops survive.
    assign drop_cnt_dec = drop_cnt - (frame_done ? shadow[7:0] : 8'd0);
    assign shadow_src   = {entry_src, drop_cnt};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                 drop_cnt <= '0;
        else if (drop && drop_cnt_dec != 8'hFF)   drop_cnt <= drop_cnt_dec + 1'b1;
        else                                      drop_cnt <= drop_cnt_dec;
    end
`else
    assign shadow_src = entry_src;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (spi_active) state_next = ST_SEND;
            ST_SEND: begin
                if (!spi_active)     state_next = ST_IDLE;
                else if (frame_done) state_next = ST_RELOAD;
            end
            ST_RELOAD: state_next = spi_active ? ST_SEND : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        load_shadow = 1'b0;
        idx_inc     = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            ST_IDLE, ST_RELOAD: load_shadow = 1'b1;
            ST_SEND: begin
                if (spi_active && byte_done) begin
                    if (idx == LAST_IDX) frame_done = 1'b1;
                    else                 idx_inc    = 1'b1;
                end
            end
            default: load_shadow = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= '0;
            shadow   <= '0;
            src_fifo <= 1'b0;
            tx_byte  <= '0;
        end else begin
            if (idx_inc)
                idx <= idx + 1'b1;
            else if (state != ST_SEND || frame_done || !spi_active)
                idx <= '0;
            if (load_shadow) begin
                shadow   <= shadow_src;
                src_fifo <= !fifo_empty;
            end
            tx_byte <= frame_byte(shadow, idx);
        end
    end

endmodule
